// File: rtl/sync_fifo_ctrl.sv
// FIFO controller that fronts an external synchronous memory (1-cycle read latency) with a
// 2-entry output buffer, so a word can be pushed and a word popped on every cycle.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wp;
  logic [ADDR_WIDTH-1:0] r_rp;
  logic [ADDR_WIDTH:0]   r_mem_cnt;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_rd_pend;
  logic [1:0]            r_buf_cnt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic       w_push;
  logic       w_pop;
  logic       w_rd_issue;
  logic [2:0] w_occ;
  logic [1:0] w_cnt_after_pop;

  assign in_ready  = (r_level < DEPTH_L);
  assign out_valid = (r_buf_cnt != 2'd0);
  assign out_data  = r_head;
  assign level     = r_level;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Buffer slots that will be occupied next cycle if no new read is issued now; an
  // issue is only allowed when its returning word is guaranteed a free slot.
  assign w_occ           = {1'b0, r_buf_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_rd_issue      = ((r_mem_cnt != '0) || w_push) && (w_occ < 3'd2);
  assign w_cnt_after_pop = r_buf_cnt - {1'b0, w_pop};

  assign mem_wr_en   = w_push;
  assign mem_wr_addr = r_wp;
  assign mem_wr_data = in_data;
  assign mem_rd_addr = r_rp;

  // NOTE: state registers use non-blocking assignments so every process samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_mem_cnt <= '0;
      r_level   <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_push)     r_wp <= r_wp + ADDR_WIDTH'(1);
      if (w_rd_issue) r_rp <= r_rp + ADDR_WIDTH'(1);
      r_mem_cnt <= r_mem_cnt + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_rd_issue);
      r_level   <= r_level + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_pop);
      r_rd_pend <= w_rd_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_cnt <= 2'd0;
      r_head    <= '0;
      r_skid    <= '0;
    end else begin
      if (w_pop) r_head <= r_skid;
      // NOTE: the returning read word lands after the pop shift; a later assignment to r_head wins.
      if (r_rd_pend) begin
        if (w_cnt_after_pop == 2'd0) r_head <= mem_rd_data;
        else                         r_skid <= mem_rd_data;
      end
      r_buf_cnt <= w_cnt_after_pop + {1'b0, r_rd_pend};
    end
  end

endmodule
